// File: rtl/axilite4_decoder_if.sv
// One AXI-Lite 4 port: read address/data and write address/data/response channels.
// The master modport drives requests; the slave modport answers them.
interface axilite4_decoder_if;
  logic [31:0] readAddr_addr;
  logic        readAddr_valid;
  logic        readAddr_ready;
  logic [31:0] readData_data;
  logic        readData_valid;
  logic        readData_ready;
  logic [31:0] writeAddr_addr;
  logic        writeAddr_valid;
  logic        writeAddr_ready;
  logic [31:0] writeData_data;
  logic        writeData_valid;
  logic        writeData_ready;
  logic [31:0] writeResp_msg;
  logic        writeResp_valid;
  logic        writeResp_ready;

  modport master (
    output readAddr_addr, readAddr_valid, input  readAddr_ready,
    input  readData_data, readData_valid, output readData_ready,
    output writeAddr_addr, writeAddr_valid, input writeAddr_ready,
    output writeData_data, writeData_valid, input writeData_ready,
    input  writeResp_msg, writeResp_valid, output writeResp_ready
  );

  modport slave (
    input  readAddr_addr, readAddr_valid, output readAddr_ready,
    output readData_data, readData_valid, input  readData_ready,
    input  writeAddr_addr, writeAddr_valid, output writeAddr_ready,
    input  writeData_data, writeData_valid, output writeData_ready,
    output writeResp_msg, writeResp_valid, input  writeResp_ready
  );
endinterface

// File: rtl/axilite4_decoder.sv
// Single-master to two-slave AXI-Lite 4 address decoder with independent read/write FSMs.
// Unmapped addresses are answered locally with ERR_DATA / ERR_RESP.
module axilite4_decoder #(
  parameter logic [31:0] S0_BASE  = 32'h0000_0000,
  parameter logic [31:0] S0_MASK  = 32'hFFFF_0000,
  parameter logic [31:0] S1_BASE  = 32'h0001_0000,
  parameter logic [31:0] S1_MASK  = 32'hFFFF_0000,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
  parameter logic [31:0] ERR_RESP = 32'h0000_0003
) (
  input  logic                       clk,
  input  logic                       rst,
  axilite4_decoder_if.slave          up,
  axilite4_decoder_if.master         s0,
  axilite4_decoder_if.master         s1
);

  typedef enum logic [1:0] {SEL_S0 = 2'd0, SEL_S1 = 2'd1, SEL_ERR = 2'd2} sel_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_RESP = 2'd2, R_ERR = 2'd3} r_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2, W_ERR = 2'd3} w_state_e;

  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;
  sel_e     rsel_q, rsel_d;
  sel_e     wsel_q, wsel_d;

  // Slave 0 takes priority where the two windows overlap.
  function automatic sel_e decode(input logic [31:0] addr);
    if ((addr & S0_MASK) == S0_BASE) begin
      decode = SEL_S0;
    end else if ((addr & S1_MASK) == S1_BASE) begin
      decode = SEL_S1;
    end else begin
      decode = SEL_ERR;
    end
  endfunction

  // State and routing registers for both paths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      rsel_q    <= SEL_S0;
      wsel_q    <= SEL_S0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      rsel_q    <= rsel_d;
      wsel_q    <= wsel_d;
    end
  end

  // Read path: next state and channel routing.
  always_comb begin
    r_state_d           = r_state_q;
    rsel_d              = rsel_q;
    up.readAddr_ready   = 1'b0;
    up.readData_data    = 32'h0000_0000;
    up.readData_valid   = 1'b0;
    s0.readAddr_addr    = 32'h0000_0000;
    s0.readAddr_valid   = 1'b0;
    s0.readData_ready   = 1'b0;
    s1.readAddr_addr    = 32'h0000_0000;
    s1.readAddr_valid   = 1'b0;
    s1.readData_ready   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (up.readAddr_valid) begin
          rsel_d    = decode(up.readAddr_addr);
          r_state_d = R_REQ;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_REQ: begin
        case (rsel_q)
          SEL_S0: begin
            s0.readAddr_addr  = up.readAddr_addr;
            s0.readAddr_valid = up.readAddr_valid;
            up.readAddr_ready = s0.readAddr_ready;
            if (up.readAddr_valid && s0.readAddr_ready) r_state_d = R_RESP;
            else r_state_d = R_REQ;
          end
          SEL_S1: begin
            s1.readAddr_addr  = up.readAddr_addr;
            s1.readAddr_valid = up.readAddr_valid;
            up.readAddr_ready = s1.readAddr_ready;
            if (up.readAddr_valid && s1.readAddr_ready) r_state_d = R_RESP;
            else r_state_d = R_REQ;
          end
          default: begin
            up.readAddr_ready = 1'b1;
            r_state_d         = R_ERR;
          end
        endcase
      end
      R_RESP: begin
        case (rsel_q)
          SEL_S0: begin
            up.readData_data  = s0.readData_data;
            up.readData_valid = s0.readData_valid;
            s0.readData_ready = up.readData_ready;
            if (s0.readData_valid && up.readData_ready) r_state_d = R_IDLE;
            else r_state_d = R_RESP;
          end
          SEL_S1: begin
            up.readData_data  = s1.readData_data;
            up.readData_valid = s1.readData_valid;
            s1.readData_ready = up.readData_ready;
            if (s1.readData_valid && up.readData_ready) r_state_d = R_IDLE;
            else r_state_d = R_RESP;
          end
          default: r_state_d = R_IDLE;
        endcase
      end
      R_ERR: begin
        up.readData_valid = 1'b1;
        up.readData_data  = ERR_DATA;
        if (up.readData_ready) r_state_d = R_IDLE;
        else r_state_d = R_ERR;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write path: address and data are forwarded and accepted together.
  always_comb begin
    w_state_d          = w_state_q;
    wsel_d             = wsel_q;
    up.writeAddr_ready = 1'b0;
    up.writeData_ready = 1'b0;
    up.writeResp_msg   = 32'h0000_0000;
    up.writeResp_valid = 1'b0;
    s0.writeAddr_addr  = 32'h0000_0000;
    s0.writeAddr_valid = 1'b0;
    s0.writeData_data  = 32'h0000_0000;
    s0.writeData_valid = 1'b0;
    s0.writeResp_ready = 1'b0;
    s1.writeAddr_addr  = 32'h0000_0000;
    s1.writeAddr_valid = 1'b0;
    s1.writeData_data  = 32'h0000_0000;
    s1.writeData_valid = 1'b0;
    s1.writeResp_ready = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (up.writeAddr_valid && up.writeData_valid) begin
          wsel_d    = decode(up.writeAddr_addr);
          w_state_d = W_REQ;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_REQ: begin
        case (wsel_q)
          SEL_S0: begin
            s0.writeAddr_addr  = up.writeAddr_addr;
            s0.writeData_data  = up.writeData_data;
            s0.writeAddr_valid = up.writeAddr_valid && up.writeData_valid;
            s0.writeData_valid = up.writeAddr_valid && up.writeData_valid;
            up.writeAddr_ready = s0.writeAddr_ready && s0.writeData_ready;
            up.writeData_ready = s0.writeAddr_ready && s0.writeData_ready;
            if (up.writeAddr_valid && up.writeData_valid && s0.writeAddr_ready && s0.writeData_ready)
              w_state_d = W_RESP;
            else
              w_state_d = W_REQ;
          end
          SEL_S1: begin
            s1.writeAddr_addr  = up.writeAddr_addr;
            s1.writeData_data  = up.writeData_data;
            s1.writeAddr_valid = up.writeAddr_valid && up.writeData_valid;
            s1.writeData_valid = up.writeAddr_valid && up.writeData_valid;
            up.writeAddr_ready = s1.writeAddr_ready && s1.writeData_ready;
            up.writeData_ready = s1.writeAddr_ready && s1.writeData_ready;
            if (up.writeAddr_valid && up.writeData_valid && s1.writeAddr_ready && s1.writeData_ready)
              w_state_d = W_RESP;
            else
              w_state_d = W_REQ;
          end
          default: begin
            up.writeAddr_ready = 1'b1;
            up.writeData_ready = 1'b1;
            w_state_d          = W_ERR;
          end
        endcase
      end
      W_RESP: begin
        case (wsel_q)
          SEL_S0: begin
            up.writeResp_msg   = s0.writeResp_msg;
            up.writeResp_valid = s0.writeResp_valid;
            s0.writeResp_ready = up.writeResp_ready;
            if (s0.writeResp_valid && up.writeResp_ready) w_state_d = W_IDLE;
            else w_state_d = W_RESP;
          end
          SEL_S1: begin
            up.writeResp_msg   = s1.writeResp_msg;
            up.writeResp_valid = s1.writeResp_valid;
            s1.writeResp_ready = up.writeResp_ready;
            if (s1.writeResp_valid && up.writeResp_ready) w_state_d = W_IDLE;
            else w_state_d = W_RESP;
          end
          default: w_state_d = W_IDLE;
        endcase
      end
      W_ERR: begin
        up.writeResp_valid = 1'b1;
        up.writeResp_msg   = ERR_RESP;
        if (up.writeResp_ready) w_state_d = W_IDLE;
        else w_state_d = W_ERR;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axilite4_decoder.sv
// Directed bench for axilite4_decoder: each task drives one scenario and checks
// outputs half a clock after the rising edge.
module tb_axilite4_decoder;
  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  axilite4_decoder_if up_if ();
  axilite4_decoder_if s0_if ();
  axilite4_decoder_if s1_if ();

  axilite4_decoder dut (
    .clk (clk),
    .rst (rst),
    .up  (up_if),
    .s0  (s0_if),
    .s1  (s1_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    up_if.readAddr_addr   = 32'h0;  up_if.readAddr_valid  = 1'b0;
    up_if.readData_ready  = 1'b0;
    up_if.writeAddr_addr  = 32'h0;  up_if.writeAddr_valid = 1'b0;
    up_if.writeData_data  = 32'h0;  up_if.writeData_valid = 1'b0;
    up_if.writeResp_ready = 1'b0;
    s0_if.readAddr_ready  = 1'b0;  s0_if.readData_data  = 32'h0; s0_if.readData_valid  = 1'b0;
    s0_if.writeAddr_ready = 1'b0;  s0_if.writeData_ready = 1'b0;
    s0_if.writeResp_msg   = 32'h0; s0_if.writeResp_valid = 1'b0;
    s1_if.readAddr_ready  = 1'b0;  s1_if.readData_data  = 32'h0; s1_if.readData_valid  = 1'b0;
    s1_if.writeAddr_ready = 1'b0;  s1_if.writeData_ready = 1'b0;
    s1_if.writeResp_msg   = 32'h0; s1_if.writeResp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #1;
    checks++; if ({up_if.readAddr_ready, up_if.readData_valid, up_if.writeAddr_ready, up_if.writeData_ready, up_if.writeResp_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_up_flags got=%b exp=00000", {up_if.readAddr_ready, up_if.readData_valid, up_if.writeAddr_ready, up_if.writeData_ready, up_if.writeResp_valid}); end
    checks++; if ({s0_if.readAddr_valid, s0_if.writeAddr_valid, s1_if.readAddr_valid, s1_if.writeData_valid} !== 4'b0) begin
      errors++; $display("FAIL reset_slave_valids got=%b exp=0000", {s0_if.readAddr_valid, s0_if.writeAddr_valid, s1_if.readAddr_valid, s1_if.writeData_valid}); end
    checks++; if (up_if.readData_data !== 32'h0 || up_if.writeResp_msg !== 32'h0) begin
      errors++; $display("FAIL reset_data got=%h/%h exp=0/0", up_if.readData_data, up_if.writeResp_msg); end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_read_s0();
    up_if.readAddr_addr = 32'h0000_0010; up_if.readAddr_valid = 1'b1; up_if.readData_ready = 1'b1;
    s0_if.readAddr_ready = 1'b1; s0_if.readData_data = 32'h1234_5678; s0_if.readData_valid = 1'b1;
    #1;
    checks++; if (up_if.readAddr_ready !== 1'b0 || s0_if.readAddr_valid !== 1'b0) begin
      errors++; $display("FAIL rd0_idle got=%b%b exp=00", up_if.readAddr_ready, s0_if.readAddr_valid); end
    step(); #1;
    checks++; if (s0_if.readAddr_valid !== 1'b1 || s0_if.readAddr_addr !== 32'h0000_0010 || up_if.readAddr_ready !== 1'b1) begin
      errors++; $display("FAIL rd0_req got=%b %h %b exp=1 00000010 1", s0_if.readAddr_valid, s0_if.readAddr_addr, up_if.readAddr_ready); end
    checks++; if (s0_if.readData_ready !== 1'b0 || s1_if.readAddr_valid !== 1'b0) begin
      errors++; $display("FAIL rd0_req_quiet got=%b%b exp=00", s0_if.readData_ready, s1_if.readAddr_valid); end
    step(); up_if.readAddr_valid = 1'b0; #1;
    checks++; if (up_if.readData_valid !== 1'b1 || up_if.readData_data !== 32'h1234_5678 || s0_if.readData_ready !== 1'b1) begin
      errors++; $display("FAIL rd0_resp got=%b %h %b exp=1 12345678 1", up_if.readData_valid, up_if.readData_data, s0_if.readData_ready); end
    checks++; if (s1_if.readData_ready !== 1'b0 || s0_if.readAddr_valid !== 1'b0) begin
      errors++; $display("FAIL rd0_resp_quiet got=%b%b exp=00", s1_if.readData_ready, s0_if.readAddr_valid); end
    step(); #1;
    checks++; if (up_if.readData_valid !== 1'b0 || s0_if.readData_ready !== 1'b0) begin
      errors++; $display("FAIL rd0_unsolicited got=%b%b exp=00", up_if.readData_valid, s0_if.readData_ready); end
    clear_inputs(); step();
  endtask

  task automatic test_write_s1();
    up_if.writeAddr_addr = 32'h0001_0004; up_if.writeAddr_valid = 1'b1;
    up_if.writeData_data = 32'hA5A5_A5A5; up_if.writeData_valid = 1'b1; up_if.writeResp_ready = 1'b1;
    #1;
    checks++; if (up_if.writeAddr_ready !== 1'b0 || s1_if.writeAddr_valid !== 1'b0) begin
      errors++; $display("FAIL wr1_idle got=%b%b exp=00", up_if.writeAddr_ready, s1_if.writeAddr_valid); end
    step(); #1;
    checks++; if (s1_if.writeAddr_valid !== 1'b1 || s1_if.writeData_valid !== 1'b1 || s1_if.writeAddr_addr !== 32'h0001_0004 || s1_if.writeData_data !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL wr1_req got=%b%b %h %h exp=11 00010004 a5a5a5a5", s1_if.writeAddr_valid, s1_if.writeData_valid, s1_if.writeAddr_addr, s1_if.writeData_data); end
    checks++; if (up_if.writeAddr_ready !== 1'b0 || up_if.writeData_ready !== 1'b0 || s0_if.writeAddr_valid !== 1'b0) begin
      errors++; $display("FAIL wr1_c1_wait got=%b%b%b exp=000", up_if.writeAddr_ready, up_if.writeData_ready, s0_if.writeAddr_valid); end
    step(); #1;
    checks++; if (up_if.writeAddr_ready !== 1'b0 || up_if.writeData_ready !== 1'b0) begin
      errors++; $display("FAIL wr1_c2_wait got=%b%b exp=00", up_if.writeAddr_ready, up_if.writeData_ready); end
    step(); s1_if.writeAddr_ready = 1'b1; s1_if.writeData_ready = 1'b1; #1;
    checks++; if (up_if.writeAddr_ready !== 1'b1 || up_if.writeData_ready !== 1'b1) begin
      errors++; $display("FAIL wr1_c3_ready got=%b%b exp=11", up_if.writeAddr_ready, up_if.writeData_ready); end
    step();
    up_if.writeAddr_valid = 1'b0; up_if.writeData_valid = 1'b0;
    s1_if.writeAddr_ready = 1'b0; s1_if.writeData_ready = 1'b0;
    s1_if.writeResp_msg = 32'h0; s1_if.writeResp_valid = 1'b1; #1;
    checks++; if (up_if.writeResp_valid !== 1'b1 || up_if.writeResp_msg !== 32'h0 || s1_if.writeResp_ready !== 1'b1) begin
      errors++; $display("FAIL wr1_resp got=%b %h %b exp=1 00000000 1", up_if.writeResp_valid, up_if.writeResp_msg, s1_if.writeResp_ready); end
    step(); #1;
    checks++; if (up_if.writeResp_valid !== 1'b0 || s1_if.writeResp_ready !== 1'b0) begin
      errors++; $display("FAIL wr1_done got=%b%b exp=00", up_if.writeResp_valid, s1_if.writeResp_ready); end
    clear_inputs(); step();
  endtask

  task automatic test_unmapped();
    up_if.readAddr_addr = 32'h0002_0000; up_if.readAddr_valid = 1'b1;
    s0_if.readAddr_ready = 1'b1; s1_if.readAddr_ready = 1'b1;
    step(); #1;
    checks++; if (up_if.readAddr_ready !== 1'b1 || s0_if.readAddr_valid !== 1'b0 || s1_if.readAddr_valid !== 1'b0) begin
      errors++; $display("FAIL err_rd_req got=%b%b%b exp=100", up_if.readAddr_ready, s0_if.readAddr_valid, s1_if.readAddr_valid); end
    step(); up_if.readAddr_valid = 1'b0; #1;
    checks++; if (up_if.readData_valid !== 1'b1 || up_if.readData_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL err_rd_data got=%b %h exp=1 deadbeef", up_if.readData_valid, up_if.readData_data); end
    step(); up_if.readData_ready = 1'b1; #1;
    checks++; if (up_if.readData_valid !== 1'b1 || up_if.readData_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL err_rd_hold got=%b %h exp=1 deadbeef", up_if.readData_valid, up_if.readData_data); end
    step(); #1;
    checks++; if (up_if.readData_valid !== 1'b0) begin
      errors++; $display("FAIL err_rd_done got=%b exp=0", up_if.readData_valid); end
    clear_inputs();
    up_if.writeAddr_addr = 32'h0002_0000; up_if.writeAddr_valid = 1'b1;
    up_if.writeData_data = 32'h0000_00FF; up_if.writeData_valid = 1'b1;
    s0_if.writeAddr_ready = 1'b1; s0_if.writeData_ready = 1'b1;
    step(); #1;
    checks++; if (up_if.writeAddr_ready !== 1'b1 || up_if.writeData_ready !== 1'b1 || s0_if.writeAddr_valid !== 1'b0 || s1_if.writeData_valid !== 1'b0) begin
      errors++; $display("FAIL err_wr_req got=%b%b%b%b exp=1100", up_if.writeAddr_ready, up_if.writeData_ready, s0_if.writeAddr_valid, s1_if.writeData_valid); end
    step(); up_if.writeAddr_valid = 1'b0; up_if.writeData_valid = 1'b0; up_if.writeResp_ready = 1'b1; #1;
    checks++; if (up_if.writeResp_valid !== 1'b1 || up_if.writeResp_msg !== 32'h0000_0003) begin
      errors++; $display("FAIL err_wr_msg got=%b %h exp=1 00000003", up_if.writeResp_valid, up_if.writeResp_msg); end
    step(); #1;
    checks++; if (up_if.writeResp_valid !== 1'b0) begin
      errors++; $display("FAIL err_wr_done got=%b exp=0", up_if.writeResp_valid); end
    clear_inputs(); step();
  endtask

  task automatic test_concurrent();
    up_if.readAddr_addr = 32'h0000_0100; up_if.readAddr_valid = 1'b1; up_if.readData_ready = 1'b1;
    up_if.writeAddr_addr = 32'h0001_0008; up_if.writeAddr_valid = 1'b1;
    up_if.writeData_data = 32'h1122_3344; up_if.writeData_valid = 1'b1; up_if.writeResp_ready = 1'b1;
    s0_if.readAddr_ready = 1'b1; s0_if.readData_data = 32'hCAFE_F00D; s0_if.readData_valid = 1'b1;
    s1_if.writeAddr_ready = 1'b1; s1_if.writeData_ready = 1'b1;
    s1_if.writeResp_msg = 32'h0000_0002; s1_if.writeResp_valid = 1'b1;
    step(); #1;
    checks++; if (up_if.readAddr_ready !== 1'b1 || up_if.writeAddr_ready !== 1'b1 || s1_if.writeData_data !== 32'h1122_3344 || s0_if.readAddr_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL conc_req got=%b%b %h %h exp=11 11223344 00000100", up_if.readAddr_ready, up_if.writeAddr_ready, s1_if.writeData_data, s0_if.readAddr_addr); end
    step(); up_if.readAddr_valid = 1'b0; up_if.writeAddr_valid = 1'b0; up_if.writeData_valid = 1'b0; #1;
    checks++; if (up_if.readData_data !== 32'hCAFE_F00D || up_if.writeResp_msg !== 32'h0000_0002 || up_if.readData_valid !== 1'b1 || up_if.writeResp_valid !== 1'b1) begin
      errors++; $display("FAIL conc_resp got=%h %h %b%b exp=cafef00d 00000002 11", up_if.readData_data, up_if.writeResp_msg, up_if.readData_valid, up_if.writeResp_valid); end
    step(); #1;
    checks++; if (up_if.readData_valid !== 1'b0 || up_if.writeResp_valid !== 1'b0) begin
      errors++; $display("FAIL conc_done got=%b%b exp=00", up_if.readData_valid, up_if.writeResp_valid); end
    clear_inputs(); step();
  endtask

  task automatic test_back_pressure();
    up_if.readAddr_addr = 32'h0000_0020; up_if.readAddr_valid = 1'b1;
    s0_if.readAddr_ready = 1'b1; s0_if.readData_data = 32'h0BAD_CAFE; s0_if.readData_valid = 1'b1;
    step(); step(); up_if.readAddr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (up_if.readData_valid !== 1'b1 || up_if.readData_data !== 32'h0BAD_CAFE || s0_if.readData_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got=%b %h %b exp=1 0badcafe 0", i, up_if.readData_valid, up_if.readData_data, s0_if.readData_ready); end
      step();
    end
    up_if.readData_ready = 1'b1; #1;
    checks++; if (s0_if.readData_ready !== 1'b1 || up_if.readData_data !== 32'h0BAD_CAFE) begin
      errors++; $display("FAIL bp_release got=%b %h exp=1 0badcafe", s0_if.readData_ready, up_if.readData_data); end
    step(); #1;
    checks++; if (up_if.readData_valid !== 1'b0) begin
      errors++; $display("FAIL bp_idle got=%b exp=0", up_if.readData_valid); end
    clear_inputs(); step();
  endtask

  task automatic test_reset_mid();
    up_if.readAddr_addr = 32'h0000_0040; up_if.readAddr_valid = 1'b1;
    s0_if.readAddr_ready = 1'b1; s0_if.readData_data = 32'h7777_8888; s0_if.readData_valid = 1'b1;
    step(); step(); up_if.readAddr_valid = 1'b0; #1;
    checks++; if (up_if.readData_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre got=%b exp=1", up_if.readData_valid); end
    #1 rst = 1'b1; #1;
    checks++; if (up_if.readData_valid !== 1'b0 || up_if.readData_data !== 32'h0 || s0_if.readData_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async got=%b %h %b exp=0 00000000 0", up_if.readData_valid, up_if.readData_data, s0_if.readData_ready); end
    step(); rst = 1'b0; up_if.readData_ready = 1'b1; step(); #1;
    checks++; if (up_if.readData_valid !== 1'b0 || s0_if.readAddr_valid !== 1'b0 || s0_if.readData_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_noreplay got=%b%b%b exp=000", up_if.readData_valid, s0_if.readAddr_valid, s0_if.readData_ready); end
    clear_inputs(); step();
    up_if.readAddr_addr = 32'h0001_0020; up_if.readAddr_valid = 1'b1; up_if.readData_ready = 1'b1;
    s1_if.readAddr_ready = 1'b1; s1_if.readData_data = 32'h5555_AAAA; s1_if.readData_valid = 1'b1;
    step(); #1;
    checks++; if (s1_if.readAddr_valid !== 1'b1 || s1_if.readAddr_addr !== 32'h0001_0020 || s0_if.readAddr_valid !== 1'b0) begin
      errors++; $display("FAIL rst_s1_req got=%b %h %b exp=1 00010020 0", s1_if.readAddr_valid, s1_if.readAddr_addr, s0_if.readAddr_valid); end
    step(); up_if.readAddr_valid = 1'b0; #1;
    checks++; if (up_if.readData_valid !== 1'b1 || up_if.readData_data !== 32'h5555_AAAA || s1_if.readData_ready !== 1'b1) begin
      errors++; $display("FAIL rst_s1_resp got=%b %h %b exp=1 5555aaaa 1", up_if.readData_valid, up_if.readData_data, s1_if.readData_ready); end
    step(); #1;
    checks++; if (up_if.readData_valid !== 1'b0) begin
      errors++; $display("FAIL rst_s1_done got=%b exp=0", up_if.readData_valid); end
    clear_inputs(); step();
  endtask

  initial begin
    test_reset();
    test_read_s0();
    test_write_s1();
    test_unmapped();
    test_concurrent();
    test_back_pressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axilite4_decoder.md
# axilite4_decoder

Single-master to two-slave AXI-Lite 4 address decoder; the counterpart of the slave-side arbitration mux. It sits directly behind one master device and routes each read and write transaction to slave 0 or slave 1 by address window. Unmapped addresses are terminated locally with a fixed error response. Read and write paths are independent, so one read and one write can be in flight at the same time.

## Interface
- S0_BASE, 32'h0000_0000, slave 0 window base
- S0_MASK, 32'hFFFF_0000, slave 0 window mask
- S1_BASE, 32'h0001_0000, slave 1 window base
- S1_MASK, 32'hFFFF_0000, slave 1 window mask
- ERR_DATA, 32'hDEAD_BEEF, read data returned for an unmapped address
- ERR_RESP, 32'h0000_0003, write response msg returned for an unmapped address
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- up_readAddr_addr/valid  in  32/1, up_readAddr_ready  out  1  master read-address channel
- up_readData_data/valid  out  32/1, up_readData_ready  in  1  master read-data channel
- up_writeAddr_addr/valid  in  32/1, up_writeAddr_ready  out  1  master write-address channel
- up_writeData_data/valid  in  32/1, up_writeData_ready  out  1  master write-data channel
- up_writeResp_msg/valid  out  32/1, up_writeResp_ready  in  1  master write-response channel
- s{0,1}_readAddr_addr/valid  out  32/1, s{0,1}_readAddr_ready  in  1  slave read-address channels
- s{0,1}_readData_data/valid  in  32/1, s{0,1}_readData_ready  out  1  slave read-data channels
- s{0,1}_writeAddr_addr/valid  out  32/1, s{0,1}_writeAddr_ready  in  1  slave write-address channels
- s{0,1}_writeData_data/valid  out  32/1, s{0,1}_writeData_ready  in  1  slave write-data channels
- s{0,1}_writeResp_msg/valid  in  32/1, s{0,1}_writeResp_ready  out  1  slave write-response channels

## Operation
- Decode: hit_k = ((addr & Sk_MASK) == Sk_BASE). S0 wins on overlap. A miss on both windows selects ERR.
- Read FSM states: R_IDLE, R_REQ, R_RESP, R_ERR. Registered sel_r is one of {S0, S1, ERR}.
  - R_IDLE: when up_readAddr_valid=1, latch sel_r = decode(up_readAddr_addr). Go to R_REQ. Up ready stays 0 in this state.
  - R_REQ with sel_r=Sk: drive sk_readAddr_addr/valid from the master and up_readAddr_ready = sk_readAddr_ready. On valid&ready, go to R_RESP.
  - R_REQ with sel_r=ERR: up_readAddr_ready=1; go to R_ERR.
  - R_RESP: drive up_readData_data/valid from sk and sk_readData_ready = up_readData_ready. On valid&ready, go to R_IDLE.
  - R_ERR: up_readData_valid=1 with data=ERR_DATA. When up_readData_ready=1, go to R_IDLE.
- Write FSM states: W_IDLE, W_REQ, W_RESP, W_ERR. Registered sel_w.
  - W_IDLE: when up_writeAddr_valid & up_writeData_valid, latch sel_w from the write address. Go to W_REQ.
  - W_REQ with sel_w=Sk:
    - sk_writeAddr_valid = sk_writeData_valid = up_writeAddr_valid & up_writeData_valid.
    - up_writeAddr_ready = up_writeData_ready = sk_writeAddr_ready & sk_writeData_ready.
    - The address and data handshakes are atomic: both complete in the same cycle, then go to W_RESP.
  - W_REQ with sel_w=ERR: both up readies=1 for one cycle; go to W_ERR.
  - W_RESP: pass sk_writeResp msg/valid up and up_writeResp_ready down. Handshake returns to W_IDLE.
  - W_ERR: up_writeResp_valid=1 with msg=ERR_RESP until up_writeResp_ready=1, then go to W_IDLE.
- Any channel that is not selected, or not in its phase: valid/ready outputs are 0 and data/addr/msg outputs are 32'h0.
- The address and data paths are combinational pass-through. Only the state and sel registers are clocked.

## Timing
- Reset (asynchronous): both FSMs go to IDLE, sel=S0, and every valid/ready output is 0 and every data output is 0 immediately, without waiting for a clock.
- Reset asserted mid-transaction aborts the transaction. After release, no stale valid is replayed.
- Decode latency is 1 cycle: the earliest up ready is the cycle after valid is first seen in IDLE.
- Minimum read is 3 cycles (IDLE, REQ, RESP) when the slave and master are always ready. A write takes the same.
- The master must hold addr/data stable while valid is high (AXI rule); sel is not re-evaluated until IDLE.
- Read and write may target the same slave at the same time; there is no cross-path interlock.
- A slave response that arrives without a matching outstanding request is ignored: its ready output stays 0.

## Test plan
- Read 0x0000_0010, s0 ready, s0 returns 0x1234_5678 → s0_readAddr_valid=1 in cycle 1 and up_readData_data=0x1234_5678. s1 sees no activity.
- Write 0x0001_0004 / data 0xA5A5_A5A5, s1 asserts aw/w ready only in cycle 3, returns msg 0 → up readies high only in cycle 3, then up_writeResp_msg=0.
- Read 0x0002_0000 (unmapped) → no slave valid is asserted and up_readData_data=0xDEAD_BEEF. A write to the same address returns msg 0x3.
- Concurrent read to s0 and write to s1, issued in the same cycle → both complete independently with correct data and msg.
- Back-pressure: s0_readData_valid=1 while up_readData_ready=0 for 4 cycles → FSM holds R_RESP and data stays stable; IDLE follows the handshake.
- Assert rst while in R_RESP → all outputs go to 0 asynchronously. After release, a new read to s1 completes normally.
